player_move_ctrl: RTL and testbench



---
 rtl/player_move_ctrl_pkg.sv | 34 +++
 rtl/player_move_ctrl_if.sv | 9 +
 rtl/player_move_ctrl_timer.sv | 38 +++
 rtl/player_move_ctrl.sv | 170 +++++++++++++++++
 tb/tb_player_move_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/player_move_ctrl_pkg.sv
// Shared maze geometry, PS/2 key codes, direction encoding and movement FSM states.
// Wall ROM cells are addressed as {row, col}, so COLS is expected to stay 32.
package maze_pkg;

    localparam int COLS    = 32;
    localparam int ROWS    = 24;
    localparam int CELL_PX = 20;
    localparam int TIMER_W = 27;

    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_W     = 9'h01D;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_S     = 9'h01B;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_A     = 9'h01C;
    localparam logic [8:0] KEY_RIGHT = 9'h174;
    localparam logic [8:0] KEY_D     = 9'h023;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WAIT,
        CHECK,
        HOLD
    } state_t;

endpackage

// File: rtl/player_move_ctrl_if.sv
// Wall ROM read port: address + read strobe out, wall bit back one cycle after the strobe.
interface player_move_ctrl_if;
    logic [9:0] wall_addr;
    logic       wall_rd;
    logic       wall_data;

    modport master (output wall_addr, output wall_rd, input wall_data);
    modport slave  (input wall_addr, input wall_rd, output wall_data);
endinterface

// File: rtl/player_move_ctrl_timer.sv
// Typematic timer: fires INIT_DELAY_CYCLES active cycles after clear, then every REPEAT_CYCLES.
// Counts only while active; the count restarts on each fire.
module key_repeat_timer
    import maze_pkg::*;
#(
    parameter int INIT_DELAY_CYCLES = 30_000_000,
    parameter int REPEAT_CYCLES     = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic fire
);

    logic [TIMER_W-1:0] cnt;
    logic [TIMER_W-1:0] limit;
    logic               first;

    assign limit = first ? TIMER_W'(INIT_DELAY_CYCLES) : TIMER_W'(REPEAT_CYCLES);
    assign fire  = active && (cnt == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if (clear) begin
            cnt   <= '0;
            first <= 1'b1;
        end else if (fire) begin
            cnt   <= '0;
            first <= 1'b0;
        end else if (active) begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Held direction keys -> wall-checked single-cell steps; key to move pulse is 4 cycles.
// Define WRAP_EN to wrap off-grid steps to the opposite edge instead of bumping.
module player_move_ctrl
    import maze_pkg::*;
#(
    parameter int COLS              = maze_pkg::COLS,
    parameter int ROWS              = maze_pkg::ROWS,
    parameter int START_ROW         = 1,
    parameter int START_COL         = 1,
    parameter int INIT_DELAY_CYCLES = 30_000_000,
    parameter int REPEAT_CYCLES     = 10_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      restart,
    input  logic [511:0]              key_down,
    player_move_ctrl_if.master        wall,
    output logic [4:0]                row,
    output logic [4:0]                column,
    output logic [1:0]                dir,
    output logic                      move,
    output logic                      bump
);

    state_t     state_q, state_n;
    dir_t       dir_q, dir_n;
    logic [4:0] row_n, col_n, t_row, t_col;
    logic [9:0] addr_q, addr_n;
    logic       rd_q, rd_n, move_n, bump_n;
    logic       k_up, k_dn, k_lf, k_rt, any_key;
    logic       at_edge, blocked_edge, fire;
    dir_t       prio;

    assign k_up    = key_down[KEY_UP]    | key_down[KEY_W];
    assign k_dn    = key_down[KEY_DOWN]  | key_down[KEY_S];
    assign k_lf    = key_down[KEY_LEFT]  | key_down[KEY_A];
    assign k_rt    = key_down[KEY_RIGHT] | key_down[KEY_D];
    assign any_key = k_up | k_dn | k_lf | k_rt;

    always_comb begin
        prio = DIR_RIGHT;
        if (k_up)      prio = DIR_UP;
        else if (k_dn) prio = DIR_DOWN;
        else if (k_lf) prio = DIR_LEFT;
    end

    // Candidate cell always wraps; blocked_edge decides whether the wrap is allowed.
    always_comb begin
        t_row   = row;
        t_col   = column;
        at_edge = 1'b0;
        case (dir_q)
            DIR_UP: begin
                at_edge = (row == '0);
                t_row   = at_edge ? 5'(ROWS - 1) : row - 1'b1;
            end
            DIR_DOWN: begin
                at_edge = (row == 5'(ROWS - 1));
                t_row   = at_edge ? '0 : row + 1'b1;
            end
            DIR_LEFT: begin
                at_edge = (column == '0);
                t_col   = at_edge ? 5'(COLS - 1) : column - 1'b1;
            end
            default: begin
                at_edge = (column == 5'(COLS - 1));
                t_col   = at_edge ? '0 : column + 1'b1;
            end
        endcase
    end

`ifdef WRAP_EN
    logic unused_edge;
    assign unused_edge  = at_edge;
    assign blocked_edge = 1'b0;
`else
    assign blocked_edge = at_edge;
`endif

    always_comb begin
        state_n = state_q;
        dir_n   = dir_q;
        row_n   = row;
        col_n   = column;
        addr_n  = addr_q;
        rd_n    = 1'b0;
        move_n  = 1'b0;
        bump_n  = 1'b0;
        if (restart) begin
            state_n = IDLE;
            row_n   = 5'(START_ROW);
            col_n   = 5'(START_COL);
        end else if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: if (any_key) begin
                    dir_n   = prio;
                    state_n = LOOKUP;
                end
                LOOKUP: if (blocked_edge) begin
                    bump_n  = 1'b1;
                    state_n = HOLD;
                end else begin
                    rd_n    = 1'b1;
                    addr_n  = {t_row, t_col};
                    state_n = WAIT;
                end
                WAIT: state_n = CHECK;
                CHECK: begin
                    // Row, column and dir are unchanged since LOOKUP, so t_row/t_col still name the probed cell.
                    if (wall.wall_data) begin
                        bump_n = 1'b1;
                    end else begin
                        move_n = 1'b1;
                        row_n  = t_row;
                        col_n  = t_col;
                    end
                    state_n = HOLD;
                end
                HOLD: if (!any_key) begin
                    state_n = IDLE;
                end else if (fire) begin
                    dir_n   = prio;
                    state_n = LOOKUP;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            row     <= 5'(START_ROW);
            column  <= 5'(START_COL);
            addr_q  <= '0;
            rd_q    <= 1'b0;
            move    <= 1'b0;
            bump    <= 1'b0;
        end else begin
            state_q <= state_n;
            dir_q   <= dir_n;
            row     <= row_n;
            column  <= col_n;
            addr_q  <= addr_n;
            rd_q    <= rd_n;
            move    <= move_n;
            bump    <= bump_n;
        end
    end

    key_repeat_timer #(
        .INIT_DELAY_CYCLES (INIT_DELAY_CYCLES),
        .REPEAT_CYCLES     (REPEAT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_n == IDLE),
        .active (state_q == HOLD),
        .fire   (fire)
    );

    assign wall.wall_addr = addr_q;
    assign wall.wall_rd   = rd_q;
    assign dir            = dir_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Table-driven steps plus hand sequences (auto-repeat, restart, enable, async reset); scoreboard on move/bump.
module tb_player_move_ctrl;
    import maze_pkg::*;

`ifdef WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        logic [8:0] key;
        logic       wall;
        logic       mv;
        logic       bp;
        logic [4:0] r;
        logic [4:0] c;
        logic [1:0] d;
        int         lat;
        int         rds;
        logic [9:0] addr;
    } vec_t;

    typedef struct {
        int         at;
        logic       mv;
        logic       bp;
        logic [4:0] r;
        logic [4:0] c;
        logic [1:0] d;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b1;
    logic         restart = 1'b0;
    logic [511:0] key_down = '0;
    logic [4:0]   row, column;
    logic [1:0]   dir;
    logic         move, bump;
    logic         wall_bit = 1'b0;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   rd_cnt = 0;
    logic [9:0] rd_addr = '0;
    exp_t exp_q[$];
    vec_t vt[11];

    player_move_ctrl_if wif();

    player_move_ctrl #(
        .INIT_DELAY_CYCLES (5),
        .REPEAT_CYCLES     (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .restart  (restart),
        .key_down (key_down),
        .wall     (wif),
        .row      (row),
        .column   (column),
        .dir      (dir),
        .move     (move),
        .bump     (bump)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wall ROM: the requested bit only in the cycle after the strobe, its inverse otherwise.
    always @(posedge clk) wif.wall_data <= wif.wall_rd ? wall_bit : ~wall_bit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wif.wall_rd) begin
                rd_cnt++;
                rd_addr = wif.wall_addr;
            end
            if (move || bump) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {30'd0, move, bump}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ev_cycle", cyc, e.at);
                    chk("ev_move", move, e.mv);
                    chk("ev_bump", bump, e.bp);
                    chk("ev_row", row, e.r);
                    chk("ev_col", column, e.c);
                    chk("ev_dir", dir, e.d);
                end
            end
        end
    end

    function automatic vec_t mk(input logic [8:0] k, input logic w, input logic mv, input logic bp,
                                input int r, input int c, input int d, input int lat, input int rds,
                                input int addr);
        vec_t v;
        v.key = k; v.wall = w; v.mv = mv; v.bp = bp;
        v.r = 5'(r); v.c = 5'(c); v.d = 2'(d);
        v.lat = lat; v.rds = rds; v.addr = 10'(addr);
        return v;
    endfunction

    task automatic push_exp(input int at, input logic mv, input logic bp, input int r, input int c, input int d);
        exp_t e;
        e.at = at; e.mv = mv; e.bp = bp; e.r = 5'(r); e.c = 5'(c); e.d = 2'(d);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("event_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        wall_bit = v.wall;
        rd_cnt   = 0;
        push_exp(cyc + v.lat, v.mv, v.bp, v.r, v.c, v.d);
        key_down[v.key] = 1'b1;
        @(negedge clk);
        key_down[v.key] = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("rom_reads", rd_cnt, v.rds);
        if (v.rds != 0) chk("wall_addr", rd_addr, v.addr);
    endtask

    initial begin
        int c0;
        vt[0]  = mk(KEY_RIGHT, 0, 1, 0, 1, 2, 3, 4, 1, 34);
        vt[1]  = mk(KEY_S,     0, 1, 0, 2, 2, 1, 4, 1, 66);
        vt[2]  = mk(KEY_A,     1, 0, 1, 2, 2, 2, 4, 1, 65);
        vt[3]  = mk(KEY_LEFT,  0, 1, 0, 2, 1, 2, 4, 1, 65);
        vt[4]  = mk(KEY_LEFT,  0, 1, 0, 2, 0, 2, 4, 1, 64);
        vt[5]  = WRAP ? mk(KEY_A, 0, 1, 0, 2, 31, 2, 4, 1, 95) : mk(KEY_A, 0, 0, 1, 2, 0, 2, 2, 0, 0);
        vt[6]  = mk(KEY_W,     0, 1, 0, 1, WRAP ? 31 : 0, 0, 4, 1, WRAP ? 63 : 32);
        vt[7]  = mk(KEY_UP,    0, 1, 0, 0, WRAP ? 31 : 0, 0, 4, 1, WRAP ? 31 : 0);
        vt[8]  = WRAP ? mk(KEY_UP, 0, 1, 0, 23, 31, 0, 4, 1, 767) : mk(KEY_UP, 0, 0, 1, 0, 0, 0, 2, 0, 0);
        vt[9]  = WRAP ? mk(KEY_DOWN, 1, 0, 1, 23, 31, 1, 4, 1, 31) : mk(KEY_DOWN, 1, 0, 1, 0, 0, 1, 4, 1, 32);
        vt[10] = WRAP ? mk(KEY_D, 0, 1, 0, 23, 0, 3, 4, 1, 736) : mk(KEY_D, 0, 1, 0, 0, 1, 3, 4, 1, 1);

        repeat (2) @(negedge clk);
        chk("rst_row", row, 1);
        chk("rst_col", column, 1);
        chk("rst_dir", dir, 0);
        chk("rst_move", move, 0);
        chk("rst_bump", bump, 0);
        chk("rst_wall_rd", wif.wall_rd, 0);
        chk("rst_wall_addr", wif.wall_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i]) run_vec(vt[i]);

        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        chk("restart_row", row, 1);
        chk("restart_col", column, 1);

        // Held right: steps at +4, +13 (initial delay), then switch to down without resetting the timer.
        wall_bit = 1'b0;
        c0 = cyc;
        push_exp(c0 + 4,  1, 0, 1, 2, 3);
        push_exp(c0 + 13, 1, 0, 1, 3, 3);
        push_exp(c0 + 20, 1, 0, 2, 3, 1);
        key_down[KEY_RIGHT] = 1'b1;
        repeat (15) @(negedge clk);
        key_down[KEY_RIGHT] = 1'b0;
        key_down[KEY_DOWN]  = 1'b1;
        repeat (6) @(negedge clk);
        key_down[KEY_DOWN]  = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        chk("release_row", row, 2);
        chk("release_col", column, 3);

        // Restart lands in the WAIT cycle: the pending lookup must be dropped.
        key_down[KEY_RIGHT] = 1'b1;
        @(negedge clk);
        key_down[KEY_RIGHT] = 1'b0;
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        repeat (10) @(negedge clk);
        chk("wait_restart_row", row, 1);
        chk("wait_restart_col", column, 1);

        enable = 1'b0;
        key_down[KEY_LEFT] = 1'b1;
        @(negedge clk);
        key_down[KEY_LEFT] = 1'b0;
        repeat (8) @(negedge clk);
        chk("disabled_col", column, 1);
        enable = 1'b1;
        @(negedge clk);

        rd_cnt = 0;
        c0 = cyc;
        push_exp(c0 + 4, 1, 0, 0, 1, 0);
        key_down[KEY_UP]    = 1'b1;
        key_down[KEY_RIGHT] = 1'b1;
        @(negedge clk);
        key_down[KEY_UP]    = 1'b0;
        key_down[KEY_RIGHT] = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("prio_addr", rd_addr, 1);

        c0 = cyc;
        push_exp(c0 + 4, 1, 0, 0, 2, 3);
        key_down[KEY_RIGHT] = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_row", row, 1);
        chk("async_rst_col", column, 1);
        chk("async_rst_move", move, 0);
        chk("async_rst_dir", dir, 0);
        @(negedge clk);
        key_down[KEY_RIGHT] = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        c0 = cyc;
        push_exp(c0 + 4, 1, 0, 2, 1, 1);
        key_down[KEY_DOWN] = 1'b1;
        @(negedge clk);
        key_down[KEY_DOWN] = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        chk("events_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
